uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART serial transmitter. Accepts a parallel byte and shifts it out on the line as start bit, DBIT data bits (LSB first), optional parity, and stop bit(s).
- Timing comes from the shared baud-rate generator's s_tick, at 16 ticks per bit.
- Sits between the FIFO/interface logic and the tx pin. Frame format matches the companion receiver.

Parameters:
- DBIT, 8: number of data bits, legal range 6..8. din bits above DBIT-1 are ignored.
- SB_TICK, 16: s_tick count for the stop interval. 16, 24 and 32 give 1, 1.5 and 2 stop bits; legal range 16..32.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_start  input  1  one-cycle request to send din; honoured only when idle.
- s_tick  input  1  oversampling enable from the baud generator (16x baud), one clk wide.
- din  input  8  byte to transmit; sampled only in the cycle tx_start is accepted.
- tx_done_tick  output  1  one-clk pulse when the last stop tick completes.
- tx_busy  output  1  high whenever state is not idle.
- tx  output  1  serial line; idle-high; registered, glitch-free.

Behaviour:
- Reset (async, immediate): state=idle, tick counter s=0, bit counter n=0, shift register b=0.
- Outputs under reset: tx=1, tx_done_tick=0, tx_busy=0.
- Reset mid-frame aborts the frame: tx returns to 1 at once and no tx_done_tick is produced.
- Counters: s is 5 bits wide; n is 3 bits wide. Shift register b is 8 bits, shifted right; the next line value is always b[0].
- The tx register is updated every clk from the next-state value, so tx tracks the current state with zero extra delay. The first start-bit low appears 1 clk after tx_start is accepted.
- idle: tx_next=1. If tx_start=1: b<=din, s<=0, go to start. s_tick is ignored in idle.
- start: tx_next=0. On s_tick: if s==15 then s<=0, n<=0, go to data; else s<=s+1.
- data: tx_next=b[0]. On s_tick: if s==15 then s<=0 and b<=b>>1.
  - If n==DBIT-1, go to stop (or to parity when the optional feature is present).
  - Otherwise n<=n+1.
  - Otherwise (s!=15), s<=s+1.
- stop: tx_next=1. On s_tick: if s==SB_TICK-1 then go to idle and assert tx_done_tick for that one clk; else s<=s+1.
- No s_tick in a cycle: state and counters hold. Ticks are counted, never clk cycles.
- Frame length, without parity: 16*(1+DBIT)+SB_TICK s_ticks.
- tx_start while busy, including the same cycle as tx_done_tick: ignored, not queued. din is not resampled.
- Back-to-back frames: tx_start in the cycle after tx_done_tick is accepted. The line then has no idle gap beyond that 1 clk.
- tx_start held high continuously: frames transmit back-to-back, each using the din value present at its acceptance cycle.
- tx_busy=1 from the clk after acceptance through the tx_done_tick cycle inclusive.
- tx_done_tick is never asserted outside the stop→idle transition.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - At acceptance, even parity p = XOR of din[DBIT-1:0] is latched.
  - A parity state is inserted between data and stop: tx_next=p for 16 s_ticks, then go to stop with s<=0.
  - Frame grows by 16 ticks.
- Undefined: the parity state and the p register do not exist; data goes directly to stop. The port list is identical in both builds.

Test Plan:
- Reset values: assert reset mid-frame (during data bit 3) → tx=1, tx_busy=0 and tx_done_tick=0 within the same cycle. After release, the next tx_start transmits normally.
- Single byte: DBIT=8, SB_TICK=16, din=0xA5, s_tick every 4 clk, tx_start pulse.
  - tx low for 16 ticks, then bits 1,0,1,0,0,1,0,1 at 16 ticks each, then high for 16 ticks.
  - Exactly one tx_done_tick after 160 ticks; tx_busy low the following cycle.
- Busy rejection: during the frame of 0x3C, pulse tx_start with din=0xFF. This includes the tx_done_tick cycle.
  - Only 0x3C is transmitted, with one tx_done_tick.
  - The line stays high afterward.
- Back-to-back: tx_start held high with din=0x55 then 0x0F.
  - Two contiguous frames, each 160 ticks.
  - The second start bit begins within 1 clk plus the next s_tick after the first tx_done_tick.
- Stop/width variants: DBIT=7, SB_TICK=32, din=0x81.
  - Data bits 1,0,0,0,0,0,0; bit 7 is not sent.
  - Stop high for 32 ticks; total frame 160 ticks.
- Parity build (UART_TX_PARITY_EN): din=0xA5 → parity bit 0; din=0x07 → parity bit 1.
  - Each parity bit lasts 16 ticks; frame is 176 ticks.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, start + DBIT data bits (LSB first) + stop, timed by 16x s_tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic       s_tick,
    input  logic [7:0] din,
    output logic       tx_done_tick,
    output logic       tx_busy,
    output logic       tx
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t     state, state_next;
    logic [4:0] s, s_next;
    logic [2:0] n, n_next;
    logic [7:0] b, b_next;
    logic       tx_next;
`ifdef UART_TX_PARITY_EN
    logic       p, p_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
            tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            p     <= 1'b0;
`endif
        end else begin
            state <= state_next;
            s     <= s_next;
            n     <= n_next;
            b     <= b_next;
            tx    <= tx_next;
`ifdef UART_TX_PARITY_EN
            p     <= p_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        s_next       = s;
        n_next       = n;
        b_next       = b;
        tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
        p_next       = p;
`endif
        case (state)
            IDLE:
                if (tx_start) begin
                    state_next = START;
                    s_next     = '0;
                    b_next     = din;
`ifdef UART_TX_PARITY_EN
                    p_next     = ^din[DBIT-1:0];
`endif
                end
            START:
                if (s_tick) begin
                    if (s == 5'd15) begin
                        state_next = DATA;
                        s_next     = '0;
                        n_next     = '0;
                    end else
                        s_next = s + 5'd1;
                end
            DATA:
                if (s_tick) begin
                    if (s == 5'd15) begin
                        s_next = '0;
                        b_next = b >> 1;
                        if (n == 3'(DBIT - 1))
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        else
                            n_next = n + 3'd1;
                    end else
                        s_next = s + 5'd1;
                end
`ifdef UART_TX_PARITY_EN
            PARITY:
                if (s_tick) begin
                    if (s == 5'd15) begin
                        state_next = STOP;
                        s_next     = '0;
                    end else
                        s_next = s + 5'd1;
                end
`endif
            STOP:
                if (s_tick) begin
                    if (s == 5'(SB_TICK - 1)) begin
                        state_next   = IDLE;
                        tx_done_tick = 1'b1;
                    end else
                        s_next = s + 5'd1;
                end
            default: state_next = IDLE;
        endcase
        // line value follows the next state so the registered tx has no extra lag
        tx_next = 1'b1;
        if (state_next == START)
            tx_next = 1'b0;
        if (state_next == DATA)
            tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
        if (state_next == PARITY)
            tx_next = p_next;
`endif
    end

    assign tx_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx (8N1 instance plus a 7-bit / 2-stop instance).
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start = 1'b0;
    logic       tx_start7 = 1'b0;
    logic       s_tick = 1'b0;
    logic [7:0] din = 8'h00;
    logic       sel = 1'b0;
    logic       poke = 1'b0;
    logic       done8, busy8, tx8, done7, busy7, tx7;
    logic       txo, busyo;
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;

    uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
        .tx_done_tick(done8), .tx_busy(busy8), .tx(tx8)
    );
    uart_tx #(.DBIT(7), .SB_TICK(32)) dut7 (
        .clk(clk), .reset(reset), .tx_start(tx_start7), .s_tick(s_tick), .din(din),
        .tx_done_tick(done7), .tx_busy(busy7), .tx(tx7)
    );

    always #5 clk = ~clk;
    assign txo   = sel ? tx7 : tx8;
    assign busyo = sel ? busy7 : busy8;

    always @(negedge clk)
        done_cnt <= done_cnt + int'(done8) + int'(done7);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // each tick: three quiet clocks, then one clock with s_tick high
    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) begin
            repeat (3) cyc();
            s_tick = 1'b1;
            if (poke) begin
                tx_start = 1'b1;
                din = 8'hFF;
            end
            cyc();
            s_tick = 1'b0;
            if (poke) tx_start = 1'b0;
        end
    endtask

    // call right after the acceptance edge; samples every bit at mid-bit
    task automatic check_frame(input logic [7:0] v, input int dbit, input int sbt,
                               input logic par, input string tag);
        int d0;
        d0 = done_cnt;
        chk({tag, " start0"}, 32'(txo), 32'd0);
        chk({tag, " busy"}, 32'(busyo), 32'd1);
        ticks(8);
        chk({tag, " start_mid"}, 32'(txo), 32'd0);
        ticks(8);
        for (int i = 0; i < dbit; i++) begin
            ticks(8);
            chk({tag, " data"}, 32'(txo), 32'(v[i]));
            ticks(8);
        end
`ifdef UART_TX_PARITY_EN
        ticks(8);
        chk({tag, " parity"}, 32'(txo), 32'(par));
        ticks(8);
`else
        chk({tag, " par_arg"}, 32'(par), 32'(par ^ 1'b0 ^ (^v[0] & 1'b0)));
`endif
        ticks(sbt / 2);
        chk({tag, " stop"}, 32'(txo), 32'd1);
        ticks(sbt - sbt / 2 - 1);
        chk({tag, " no_early_done"}, 32'(done_cnt), 32'(d0));
        chk({tag, " busy_end"}, 32'(busyo), 32'd1);
        ticks(1);
        chk({tag, " one_done"}, 32'(done_cnt), 32'(d0 + 1));
        chk({tag, " idle_busy"}, 32'(busyo), 32'd0);
        chk({tag, " idle_tx"}, 32'(txo), 32'd1);
    endtask

    initial begin
        int d;
        repeat (2) cyc();
        chk("rst_tx", 32'(tx8), 32'd1);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        reset = 1'b0;
        cyc();

        din = 8'hA5; tx_start = 1'b1; cyc(); tx_start = 1'b0;
        check_frame(8'hA5, 8, 16, 1'b0, "a5");

        din = 8'h3C; tx_start = 1'b1; cyc(); tx_start = 1'b0;
        poke = 1'b1;
        check_frame(8'h3C, 8, 16, 1'b0, "busy_rej");
        poke = 1'b0;
        d = done_cnt;
        ticks(20);
        chk("rej_line_high", 32'(tx8), 32'd1);
        chk("rej_idle", 32'(busy8), 32'd0);
        chk("rej_no_done", 32'(done_cnt), 32'(d));

        din = 8'h55; tx_start = 1'b1; cyc();
        din = 8'h0F;
        check_frame(8'h55, 8, 16, 1'b0, "b2b_1");
        cyc(); tx_start = 1'b0;
        check_frame(8'h0F, 8, 16, 1'b0, "b2b_2");

        din = 8'h07; tx_start = 1'b1; cyc(); tx_start = 1'b0;
        check_frame(8'h07, 8, 16, 1'b1, "x07");

        sel = 1'b1;
        din = 8'h81; tx_start7 = 1'b1; cyc(); tx_start7 = 1'b0;
        check_frame(8'h81, 7, 32, 1'b1, "d7s2");
        chk("d7_other_idle", 32'(busy8), 32'd0);
        sel = 1'b0;

        din = 8'hA5; tx_start = 1'b1; cyc(); tx_start = 1'b0;
        ticks(16 + 3 * 16 + 8);
        chk("mid_bit3", 32'(tx8), 32'd0);
        d = done_cnt;
        reset = 1'b1;
        #1;
        chk("arst_tx", 32'(tx8), 32'd1);
        chk("arst_busy", 32'(busy8), 32'd0);
        chk("arst_done", 32'(done8), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        chk("arst_no_done", 32'(done_cnt), 32'(d));
        din = 8'h3C; tx_start = 1'b1; cyc(); tx_start = 1'b0;
        check_frame(8'h3C, 8, 16, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
